// File: rtl/ram_loader_if.sv
// ram_loader_if: incoming word stream and RAM write port of the loader.
interface ram_loader_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic [WIDTH-1:0] ram_addr;
    logic [WIDTH-1:0] ram_data;
    logic             ram_we;
    modport slave  (input  in_valid, in_data, output in_ready, ram_addr, ram_data, ram_we);
    modport master (output in_valid, in_data, input  in_ready, ram_addr, ram_data, ram_we);
endinterface

// File: rtl/ram_loader.sv
// ram_loader: streams words into RAM from base_addr, holding the CPU off and summing what it wrote.
module ram_loader #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int WIDTH         = 8,
    parameter int MEMORY_SIZE   = 1 << ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic [ADDRESS_WIDTH-1:0] base_addr_i,
    input  logic [ADDRESS_WIDTH-1:0] load_len_i,
    ram_loader_if.slave              bus,
    output logic                     cpu_hold_o,
    output logic                     done_o,
    output logic [WIDTH-1:0]         checksum_o
);
    localparam int RW = $clog2(MEMORY_SIZE + 1);
    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
    logic [RW-1:0]            rem_q, rem_d;
    logic [WIDTH-1:0]         data_q, data_d;
    logic [WIDTH-1:0]         sum_q, sum_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            sum_q   <= sum_d;
        end
    end
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: if (start_i && !abort_i) begin
                state_d = RECV;
                ptr_d   = base_addr_i;
                rem_d   = (load_len_i == '0) ? RW'(MEMORY_SIZE) : RW'(load_len_i);
                sum_d   = '0;
            end
            RECV: begin
                if (abort_i) state_d = IDLE;
                else if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // the write itself always lands; abort only decides where we go next
                sum_d   = sum_q + data_q;
                ptr_d   = (ptr_q == ADDRESS_WIDTH'(MEMORY_SIZE - 1)) ? '0 : ptr_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                state_d = abort_i ? IDLE : (rem_q == RW'(1)) ? DONE : RECV;
            end
            default: state_d = IDLE;
        endcase
    end
    assign bus.in_ready = state_q == RECV;
    assign bus.ram_we   = state_q == WRITE;
    assign bus.ram_addr = WIDTH'(ptr_q);
    assign bus.ram_data = data_q;
    assign cpu_hold_o   = state_q != IDLE;
    assign done_o       = (state_q == DONE) && !abort_i;
    assign checksum_o   = sum_q;
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: directed loads with a write scoreboard checked by a negedge monitor.
module tb_ram_loader;
    logic       clk = 0;
    logic       rst = 1;
    logic       start_i = 0;
    logic       abort_i = 0;
    logic [3:0] base_addr_i = '0;
    logic [3:0] load_len_i = '0;
    logic       cpu_hold_o, done_o;
    logic [7:0] checksum_o;
    int compared = 0, failed = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0, n_wr = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  q[$];
    ram_loader_if #(.WIDTH(8)) lif ();
    ram_loader dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .base_addr_i(base_addr_i), .load_len_i(load_len_i), .bus(lif),
        .cpu_hold_o(cpu_hold_o), .done_o(done_o), .checksum_o(checksum_o)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (lif.ram_we) begin
            n_wr++;
            chk("write_cpu_hold", cpu_hold_o, 1);
            chk("write_in_ready", lif.in_ready, 0);
            if (exp_q.size() == 0) chk("unexpected_write", {lif.ram_addr, lif.ram_data}, 32'hFFFF_FFFF);
            else chk("ram_write", {lif.ram_addr, lif.ram_data}, exp_q.pop_front());
        end
    end
    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, lif.in_ready, 0);
        chk({tag, "_ram_we"}, lif.ram_we, 0);
        chk({tag, "_cpu_hold"}, cpu_hold_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_ram_addr"}, lif.ram_addr, 0);
        chk({tag, "_ram_data"}, lif.ram_data, 0);
        chk({tag, "_checksum"}, checksum_o, 0);
    endtask
    task automatic handshake(input logic [7:0] d);
        int k = 0;
        lif.in_valid = 1;
        lif.in_data  = d;
        while (!lif.in_ready && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        if (!lif.in_ready) chk("in_ready_wait", lif.in_ready, 1);
        chk("load_cpu_hold", cpu_hold_o, 1);
        @(posedge clk); #1;
    endtask
    task automatic wait_done(input int d0);
        int k = 0;
        while (done_cnt == d0 && k < 20) begin
            @(negedge clk); #1;
            k++;
        end
    endtask
    task automatic run_load(input logic [3:0] base, input logic [3:0] len, input logic [7:0] w[$],
                            input int stall, input bit restart);
        int d0, w0, st;
        logic [7:0] sum;
        logic [3:0] a;
        d0 = done_cnt; w0 = n_wr; sum = '0; a = base;
        foreach (w[i]) begin
            exp_q.push_back({4'h0, a, w[i]});
            a = a + 4'd1;
            sum = sum + w[i];
        end
        start_i = 1; base_addr_i = base; load_len_i = len; st = cyc;
        @(posedge clk); #1;
        start_i = 0;
        repeat (stall) begin
            chk("stall_in_ready", lif.in_ready, 1);
            chk("stall_cpu_hold", cpu_hold_o, 1);
            @(posedge clk); #1;
        end
        foreach (w[i]) begin
            if (restart && i == 1) begin
                start_i = 1; base_addr_i = 4'h0; load_len_i = 4'h5;
            end
            handshake(w[i]);
            start_i = 0;
        end
        lif.in_valid = 0;
        wait_done(d0);
        chk("done_count", done_cnt - d0, 1);
        chk("done_latency", done_cyc - st, 2 * w.size() + 1 + stall);
        chk("write_count", n_wr - w0, w.size());
        @(posedge clk); #1;
        chk("checksum", checksum_o, sum);
        chk("idle_cpu_hold", cpu_hold_o, 0);
    endtask
    initial begin
        int d0;
        lif.in_valid = 0;
        lif.in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 0;
        @(posedge clk); #1;
        q = '{8'h11, 8'h22, 8'h33};
        run_load(4'd0, 4'd3, q, 0, 0);
        abort_i = 1;
        repeat (4) @(posedge clk);
        #1;
        abort_i = 0;
        chk("checksum_hold", checksum_o, 8'h66);
        chk("idle_abort_hold", cpu_hold_o, 0);
        q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_load(4'd14, 4'd4, q, 0, 0);
        q = {};
        for (int i = 0; i < 16; i++) q.push_back(8'(3 * i + 1));
        run_load(4'd5, 4'd0, q, 0, 0);
        q = '{8'h05, 8'h07};
        run_load(4'd3, 4'd2, q, 5, 0);
        q = '{8'h10, 8'h20};
        run_load(4'd8, 4'd2, q, 0, 1);
        d0 = done_cnt;
        exp_q.push_back({8'h04, 8'hA1});
        exp_q.push_back({8'h05, 8'hA2});
        start_i = 1; base_addr_i = 4'd4; load_len_i = 4'd4;
        @(posedge clk); #1;
        start_i = 0;
        handshake(8'hA1);
        handshake(8'hA2);
        abort_i = 1;
        lif.in_valid = 0;
        chk("abort_write_we", lif.ram_we, 1);
        @(posedge clk); #1;
        abort_i = 0;
        chk("abort_cpu_hold", cpu_hold_o, 0);
        chk("abort_in_ready", lif.in_ready, 0);
        lif.in_valid = 1;
        lif.in_data  = 8'hA3;
        repeat (3) @(posedge clk);
        #1;
        lif.in_valid = 0;
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_checksum", checksum_o, 8'h43);
        chk("abort_pending", exp_q.size(), 0);
        d0 = done_cnt;
        exp_q.push_back({8'h02, 8'h5A});
        start_i = 1; base_addr_i = 4'd2; load_len_i = 4'd3;
        @(posedge clk); #1;
        start_i = 0;
        handshake(8'h5A);
        lif.in_valid = 0;
        @(posedge clk); #1;
        chk("pre_rst_in_ready", lif.in_ready, 1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check_reset_vals("rst_mid");
        repeat (3) @(posedge clk);
        #1;
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_pending", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 4, meaning the RAM address bits actually used.
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning the data word and RAM address port width.
REQ-003 The block SHALL have parameter MEMORY_SIZE, default 1 << ADDRESS_WIDTH, meaning the number of RAM words.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 start  input  1  request to begin a load; sampled only in IDLE.
REQ-007 abort  input  1  cancel the load in progress.
REQ-008 base_addr  input  ADDRESS_WIDTH  first RAM address; captured on accepted start.
REQ-009 load_len  input  ADDRESS_WIDTH  word count; captured on accepted start; 0 means MEMORY_SIZE.
REQ-010 in_valid  input  1  in_data holds a word.
REQ-011 in_data  input  WIDTH  incoming program word.
REQ-012 in_ready  output  1  block accepts a word this cycle.
REQ-013 ram_addr  output  WIDTH  RAM address, the ADDRESS_WIDTH-bit write pointer zero-extended.
REQ-014 ram_data  output  WIDTH  RAM write data.
REQ-015 ram_we  output  1  RAM write enable.
REQ-016 cpu_hold  output  1  stalls the CPU while the loader owns the RAM.
REQ-017 done  output  1  one-cycle pulse marking successful completion.
REQ-018 checksum  output  WIDTH  modulo-2^WIDTH sum of the words written in the current or last load.

Function
REQ-019 The FSM SHALL have the states IDLE, RECV, WRITE and DONE.
REQ-020 IDLE -> RECV on start=1. On that edge the block latches ptr=base_addr, remaining=load_len (0 mapped to MEMORY_SIZE), and clears checksum to 0.
REQ-021 In RECV: in_ready=1. A handshake is in_valid & in_ready. On a handshake, in_data is latched into ram_data and the state moves to WRITE. Without in_valid the state holds indefinitely.
REQ-022 In WRITE: in_ready=0 and ram_we=1 for exactly one cycle, with ram_addr={0,ptr}. On that edge: checksum += ram_data (carry discarded), ptr increments modulo MEMORY_SIZE, and remaining decrements.
REQ-023 WRITE -> DONE when remaining was 1 before the decrement; otherwise WRITE -> RECV.
REQ-024 DONE SHALL assert done=1 for one cycle, then go to IDLE unconditionally.
REQ-025 Throughput SHALL be one word per 2 cycles at most. The latency from the handshake edge to the RAM write edge is 1 cycle.
REQ-026 ptr SHALL wrap from MEMORY_SIZE-1 to 0; for example, base_addr=14 with load_len=4 writes addresses 14, 15, 0, 1.
REQ-027 cpu_hold SHALL be 1 in every state except IDLE.
REQ-028 ram_we SHALL be 0 in every state except WRITE.
REQ-029 start asserted in any state other than IDLE SHALL be ignored; base_addr and load_len SHALL NOT be re-latched.
REQ-030 abort=1 in RECV or DONE SHALL force IDLE on the next edge with no done pulse.
REQ-031 abort=1 in WRITE SHALL let that cycle's write complete (ram_we=1), then go to IDLE with no done pulse.
REQ-032 abort has priority over start; abort in IDLE has no effect.
REQ-033 checksum SHALL hold its value in IDLE until the next accepted start.
REQ-034 in_ready SHALL be 0 in IDLE, WRITE and DONE, so no word is consumed outside RECV.

Reset
REQ-035 On rst=1 at a clock edge, the block SHALL enter IDLE with ptr=0, remaining=0, ram_data=0, checksum=0, in_ready=0, ram_we=0, cpu_hold=0 and done=0.
REQ-036 rst SHALL take priority over abort and start.
REQ-037 A reset mid-load SHALL abandon the load without a done pulse; RAM contents already written are not restored.

Verification
REQ-038 Load and count check: base_addr=0, load_len=3, words 0x11, 0x22, 0x33 with in_valid held high -> writes at addresses 0, 1, 2; checksum=0x66; done pulses once, 7 cycles after start (start edge, 3x RECV/WRITE pairs); cpu_hold=1 throughout.
REQ-039 Wrap-around: base_addr=14, load_len=4, words 0xFF x4 -> writes at addresses 14, 15, 0, 1; checksum=0xFC.
REQ-040 Full-memory load: load_len=0 -> exactly 16 writes occur before done.
REQ-041 Back-pressure: in_valid low for 5 cycles in RECV -> in_ready stays 1, no write occurs, state holds; the load then completes normally.
REQ-042 Abort in WRITE of word 2 of 4 -> word 2 is written, no further ram_we, no done pulse, cpu_hold=0 on the following cycle.
REQ-043 Interfering controls: start re-asserted mid-load -> ignored; rst asserted in RECV -> every output takes its reset value on the next cycle.
